// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin arbiter that lends one shared timer to
// NUM_REQ requesters, sequencing timer reset/load/run and returning a
// one-cycle expiry pulse to the requester that owned the interval.
module timer_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TW      = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*TW-1:0] req_final_value,
    input  logic [NUM_REQ-1:0]    cancel,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    expired,
    output logic                  busy,
    output logic                  timer_resetn,
    output logic                  timer_active,
    output logic [TW-1:0]         timer_final_value,
    input  logic                  timer_done
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        last_q, last_d;
    logic [TW-1:0]        fv_q, fv_d;

    logic [IW-1:0]        cand;
    logic [IW-1:0]        pick;
    logic                 pick_vld;
    logic [TW-1:0]        pick_fv;
    logic [NUM_REQ-1:0]   owner_oh;
    logic                 req_own;
    logic                 cancel_own;

    // Round-robin search: first requester after last, wrapping; also mux its value.
    always_comb begin
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        pick_fv  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_q) + i) % NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!pick_vld && (cand == IW'(j)) && req[j]) begin
                    pick     = cand;
                    pick_vld = 1'b1;
                end
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick == IW'(j)) begin
                pick_fv = req_final_value[TW*j +: TW];
            end
        end
    end

    // Owner one-hot decode and the owner's request/cancel bits.
    always_comb begin
        owner_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            owner_oh[j] = (owner_q == IW'(j));
        end
        req_own    = |(req & owner_oh);
        cancel_own = |(cancel & owner_oh);
    end

    // Next-state logic; expiry (timer_done) outranks cancel/withdrawal in RUN.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        fv_d    = fv_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick;
                    last_d  = pick;
                    fv_d    = pick_fv;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (fv_q == '0)                 state_d = DONE;
                else if (!req_own || cancel_own) state_d = IDLE;
                else                             state_d = RUN;
            end
            RUN: begin
                if (timer_done)                  state_d = DONE;
                else if (cancel_own || !req_own) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; last resets to NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            fv_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            fv_q    <= fv_d;
        end
    end

    // Moore outputs decoded from state and owner; timer held in reset outside RUN.
    always_comb begin
        grant             = ((state_q == LOAD) || (state_q == RUN)) ? owner_oh : '0;
        expired           = (state_q == DONE) ? owner_oh : '0;
        busy              = (state_q != IDLE);
        timer_resetn      = (state_q == RUN);
        timer_active      = (state_q == RUN);
        timer_final_value = fv_q;
    end

endmodule
